// File: rtl/wu_wr_ctrl_pkg.sv
// Shared LSTM weight-update definitions: pass geometry and write-controller state type.
// The read-side address generator imports the same constants so both ends agree on pass length.
package wu_wr_ctrl_pkg;

    localparam int WU_ADDR_WIDTH = 12;
    localparam int WU_STOP       = 2809;
    localparam int WU_ROW_LEN    = 53;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wu_wr_state_t;

endpackage

// File: rtl/wu_row_counter.sv
// Modulo-ROW_LEN column counter with enable and clear; tc flags the last column of a row.
module wu_row_counter
    import wu_wr_ctrl_pkg::*;
#(
    parameter int WIDTH   = WU_ADDR_WIDTH,
    parameter int ROW_LEN = WU_ROW_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [WIDTH-1:0] LAST_COL = WIDTH'(ROW_LEN - 1);

    logic [WIDTH-1:0] col;

    assign tc = (col == LAST_COL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
        end else if (clr) begin
            col <= '0;
        end else if (en) begin
            col <= tc ? '0 : col + WIDTH'(1);
        end
    end

endmodule

// File: rtl/wu_wr_ctrl.sv
// Weight-update write-back controller: numbers the updated-weight stream 0..STOP onto the
// weight RAM write port, flags row ends, pulses done at the end of a pass, latches protocol errors.
module wu_wr_ctrl
    import wu_wr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = WU_ADDR_WIDTH,
    parameter int DATA_WIDTH = 16,
    parameter int STOP       = WU_STOP,
    parameter int ROW_LEN    = WU_ROW_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_row_end,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    if (STOP < 0 || STOP >= (1 << ADDR_WIDTH) || ROW_LEN < 1 || ROW_LEN > STOP + 1) begin : g_cfg_check
        $error("wu_wr_ctrl: STOP must fit in ADDR_WIDTH and 1 <= ROW_LEN <= STOP+1");
    end

    localparam logic [ADDR_WIDTH-1:0] STOP_ADDR = ADDR_WIDTH'(STOP);

    wu_wr_state_t          state, state_d;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  accept;
    logic                  clr;
    logic                  err_set;
    logic                  err_clr;
    logic                  at_stop;
    logic                  col_tc;

    assign at_stop = (addr == STOP_ADDR);

    wu_row_counter #(
        .WIDTH   (ADDR_WIDTH),
        .ROW_LEN (ROW_LEN)
    ) u_row_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (accept),
        .tc    (col_tc)
    );

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        clr     = 1'b0;
        err_set = 1'b0;
        err_clr = 1'b0;
        unique case (state)
            IDLE: begin
                // start wins over a coincident word: the word is dropped silently
                if (start) begin
                    state_d = RUN;
                    clr     = 1'b1;
                    err_clr = 1'b1;
                end else if (i_valid) begin
                    err_set = 1'b1;
                end
            end
            RUN: begin
                err_set = start;
                if (i_valid) begin
                    accept = 1'b1;
                    if (at_stop) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                err_set = start | i_valid;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // registered outputs: an accepted word reaches the RAM port one cycle after it is sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_row_end <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state <= state_d;
            if (clr) begin
                addr <= '0;
            end else if (accept && !at_stop) begin
                addr <= addr + ADDR_WIDTH'(1);
            end
            o_wr_en   <= accept;
            o_row_end <= accept & col_tc;
            if (accept) begin
                o_wr_addr <= addr;
                o_wr_data <= i_data;
            end
            o_busy <= (state_d != IDLE);
            o_done <= (state == DONE);
            if (err_clr) begin
                o_err <= 1'b0;
            end else if (err_set) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wu_wr_ctrl.sv
// Scoreboard bench for wu_wr_ctrl: a word-count reference model queues expected writes and
// status per cycle; an independent negedge monitor pops and compares.
module tb_wu_wr_ctrl;

    localparam int AW      = 12;
    localparam int DW      = 16;
    localparam int STOP    = 2809;
    localparam int ROW_LEN = 53;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          row_end;
    } wr_t;

    typedef struct packed {
        logic busy;
        logic err;
        logic done;
    } st_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic          o_row_end;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    wr_t wq[$];
    st_t sq[$];
    int  checks = 0;
    int  failures = 0;

    // reference model: phase 0 idle, 1 run, 2 done; m_n = words accepted this pass
    int   m_phase = 0;
    int   m_n = 0;
    logic m_err = 1'b0;

    wu_wr_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STOP       (STOP),
        .ROW_LEN    (ROW_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_wr_en   (o_wr_en),
        .o_wr_addr (o_wr_addr),
        .o_wr_data (o_wr_data),
        .o_row_end (o_row_end),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) begin
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
            end
        end
    endtask

    // monitor
    initial begin
        logic [AW-1:0] last_addr;
        logic [DW-1:0] last_data;
        last_addr = '0;
        last_data = '0;
        forever begin
            st_t es;
            wr_t ew;
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs",
                      64'({o_wr_en, o_wr_addr, o_wr_data, o_row_end, o_busy, o_done, o_err}), 64'd0);
                last_addr = '0;
                last_data = '0;
            end else begin
                if (sq.size() > 0) begin
                    es = sq.pop_front();
                    check("status_busy_err_done", 64'({o_busy, o_err, o_done}), 64'(es));
                end
                if (o_wr_en) begin
                    check("write_pending", 64'(sq.size() + wq.size()), 64'(1));
                    if (wq.size() > 0) begin
                        ew = wq.pop_front();
                        check("write_addr_data_rowend",
                              64'({o_wr_addr, o_wr_data, o_row_end}), 64'(ew));
                        last_addr = ew.addr;
                        last_data = ew.data;
                    end
                end else begin
                    check("missing_write", 64'(wq.size()), 64'd0);
                    check("hold_addr_data", 64'({o_wr_addr, o_wr_data, o_row_end}),
                          64'({last_addr, last_data, 1'b0}));
                end
            end
        end
    end

    task automatic model(input logic s, input logic v, input logic [DW-1:0] d,
                         output bit has_wr, output wr_t w, output st_t st);
        logic was_done;
        was_done = (m_phase == 2);
        has_wr   = 1'b0;
        w        = '0;
        case (m_phase)
            0: begin
                if (s) begin
                    m_phase = 1;
                    m_n     = 0;
                    m_err   = 1'b0;
                end else if (v) begin
                    m_err = 1'b1;
                end
            end
            1: begin
                if (s) m_err = 1'b1;
                if (v) begin
                    has_wr = 1'b1;
                    w = wr_t'{AW'(m_n), d, (m_n % ROW_LEN) == ROW_LEN - 1};
                    if (m_n == STOP) m_phase = 2;
                    else m_n++;
                end
            end
            default: begin
                if (s || v) m_err = 1'b1;
                m_phase = 0;
            end
        endcase
        st = st_t'{m_phase != 0, m_err, was_done};
    endtask

    task automatic step(input logic s, input logic v, input logic [DW-1:0] d);
        bit  has_wr;
        wr_t w;
        st_t st;
        start   = s;
        i_valid = v;
        i_data  = d;
        model(s, v, d, has_wr, w, st);
        @(posedge clk);
        #1;
        if (has_wr) wq.push_back(w);
        sq.push_back(st);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    // mode 0: contiguous, data = index; 1: 2-cycle gap after each row; 2: random gaps
    task automatic stream(input int mode, input int start_word, input int max_words);
        int w;
        int gap;
        w   = 0;
        gap = 0;
        while (m_phase == 1 && w < max_words) begin
            logic          v;
            logic [DW-1:0] d;
            if (mode == 1) begin
                v = (gap == 0);
                if (gap > 0) gap--;
            end else if (mode == 2) begin
                v = ($urandom_range(0, 3) != 0);
            end else begin
                v = 1'b1;
            end
            d = (mode == 0) ? DW'(w) : DW'($urandom);
            step(v && (w == start_word), v, d);
            if (v) begin
                w++;
                if (mode == 1 && (w % ROW_LEN) == 0) gap = 2;
            end
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n   = 1'b0;
        start   = 1'b0;
        i_valid = 1'b0;
        wq.delete();
        sq.delete();
        m_phase = 0;
        m_n     = 0;
        m_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // contiguous pass, then stray words in DONE and IDLE
        step(1'b1, 1'b0, '0);
        stream(0, -1, 1 << 30);
        step(1'b0, 1'b1, DW'($urandom));
        step(1'b0, 1'b1, DW'($urandom));
        idle(3);

        // row-gapped pass
        step(1'b1, 1'b0, '0);
        stream(1, -1, 1 << 30);
        idle(3);

        // word in IDLE, then start coinciding with a word, then mid-pass start
        step(1'b0, 1'b1, DW'($urandom));
        idle(2);
        step(1'b1, 1'b1, DW'($urandom));
        stream(2, 100, 1 << 30);
        idle(3);

        // reset mid-pass, fresh pass, then back-to-back restart after done
        step(1'b1, 1'b0, '0);
        stream(2, -1, 1000);
        do_reset();
        step(1'b1, 1'b0, '0);
        stream(2, -1, 1 << 30);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        stream(0, -1, 1 << 30);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wu_wr_ctrl.md
# wu_wr_ctrl

Write-back controller for the LSTM weight-update path, the write-side counterpart of the weight-update read address generator. It accepts the updated-weight stream from the update datapath with a valid qualifier, assigns consecutive weight-memory addresses 0..STOP, and drives the memory write port. Row boundaries are flagged, completion is signalled, and protocol violations are reported. It sits between the weight-update arithmetic pipeline and the weight RAM write port.

## Interface
- ADDR_WIDTH, 12, width of write address and internal counters
- DATA_WIDTH, 16, width of weight word
- STOP, 2809, last address written (inclusive); STOP+1 words per pass
- ROW_LEN, 53, words per weight row; sets row-end flag cadence

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- start  in  1  single-cycle pulse; begins a pass
- i_valid  in  1  i_data carries one updated weight this cycle
- i_data  in  DATA_WIDTH  updated weight word
- o_wr_en  out  1  RAM write enable
- o_wr_addr  out  ADDR_WIDTH  RAM write address
- o_wr_data  out  DATA_WIDTH  RAM write data
- o_row_end  out  1  high with the last word of each row (col == ROW_LEN-1)
- o_busy  out  1  high in RUN
- o_done  out  1  one-cycle pulse after the word at STOP is written
- o_err  out  1  sticky protocol-error flag

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start -> RUN; addr counter and col counter cleared to 0; o_err cleared.
  - i_valid without start: word dropped, o_err set.
- RUN: each i_valid cycle accepts one word:
  - o_wr_en=1, o_wr_addr=addr, o_wr_data=i_data.
  - addr increments by 1.
  - col increments; it wraps to 0 after ROW_LEN-1, with o_row_end=1 on that word.
- RUN gaps: i_valid low (the update pipeline's pause slots) -> o_wr_en=0; counters hold; no error.
- Word accepted at addr==STOP -> DONE. No increment past STOP; addr never wraps.
- DONE: lasts one cycle, o_done=1, then -> IDLE.
- start while in RUN or DONE: ignored, o_err set.
- start and i_valid in the same IDLE cycle: start honoured, that word dropped, o_err not set.
- o_row_end is also asserted with the STOP word if col==ROW_LEN-1 at that point. With defaults, 2810 words = 53 full rows + 1 word, so the STOP word has o_row_end=0.
- Counters are ADDR_WIDTH wide. STOP < 2^ADDR_WIDTH and ROW_LEN ≤ STOP+1 are static requirements, checked by an elaboration-time assertion.

## Timing
- All outputs registered; accepted word appears on o_wr_* exactly 1 cycle after the i_valid edge.
- o_wr_en high only for accepted words; o_wr_addr/o_wr_data hold their last values otherwise.
- o_busy rises the cycle after start is sampled. It falls in the same cycle o_done rises, which is the cycle after the STOP word's o_wr_en pulse.
- Minimum spacing between passes: next start is accepted when sampled in IDLE (the cycle after o_done).
- Reset (async assert, deassert synchronised externally):
  - all outputs 0; state IDLE; counters 0.
  - reset mid-pass discards progress with no done pulse.
- Back-to-back i_valid at full rate is supported: one write per cycle, no stall path.

## Structure
- Shared LSTM package holds:
  - the wu_wr_state_t enum (IDLE/RUN/DONE);
  - default constants WU_STOP=2809, WU_ROW_LEN=53, WU_ADDR_WIDTH=12;
  - these constants are shared with the read-side generator so both ends agree on the pass length.
- One natural sub-module: wu_row_counter, a modulo-ROW_LEN column counter with enable, clear, and a terminal-count output. It is reusable by the read side.
- FSM, address counter, and output registers live in wu_wr_ctrl.

## Test plan
- Reset then start, then 2810 contiguous i_valid cycles (data = index) -> writes at addr 0..2809 with data==addr, o_wr_en count 2810, o_done one cycle after addr 2809, o_err=0.
- Stream with a 2-cycle i_valid gap after every 53 words -> identical address/data sequence; o_row_end on addr 52, 105, …, 2808 (53 pulses); no error.
- i_valid asserted in IDLE -> no write, o_err=1. Then start -> o_err=0.
- start pulsed at word 100 mid-pass -> o_err=1, addressing continues uninterrupted to 2809, o_done pulses once.
- rst_n asserted at word 1000 -> all outputs 0 immediately. Fresh start -> first write at addr 0.
- Extra i_valid the cycle after the STOP write (state DONE/IDLE) -> no write, o_err=1, o_wr_addr remains 2809.
